encoder_position_controller: RTL

Sequencing and bookkeeping controller that sits directly downstream of the quadrature decoder in each motor channel. It turns the decoder's `count_pulse`/`direction`/`index` stream into a signed absolute position, runs the homing sequence (search for index, zero position), checks index spacing against the expected counts per revolution, and produces a windowed velocity sample for the motion control loop.

---
 rtl/encoder_position_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/encoder_position_controller.sv
// Position, homing, index-spacing and windowed-velocity bookkeeping behind a quadrature decoder.
module encoder_position_controller #(
  parameter int unsigned POS_WIDTH      = 32,
  parameter int unsigned VEL_WIDTH      = 16,
  parameter int unsigned SAMPLE_DIV     = 50000,
  parameter int unsigned COUNTS_PER_REV = 360
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 count_pulse,
  input  logic                 direction,
  input  logic                 index,
  input  logic                 enable,
  input  logic                 cmd_home,
  input  logic                 cmd_clear,
  output logic [POS_WIDTH-1:0] position,
  output logic [VEL_WIDTH-1:0] velocity,
  output logic                 velocity_valid,
  output logic                 homed,
  output logic                 homing_busy,
  output logic                 index_error
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
  localparam int unsigned ACC_W = $clog2(SAMPLE_DIV + 1) + 1;
  localparam int unsigned CMP_W = ((ACC_W > VEL_WIDTH) ? ACC_W : VEL_WIDTH) + 1;
  localparam int unsigned REV_W = 32;

  localparam logic [CMP_W-1:0]        VEL_LIM = CMP_W'(1) << (VEL_WIDTH - 1);
  localparam logic signed [CMP_W-1:0] VEL_MAX = $signed(VEL_LIM - CMP_W'(1));
  localparam logic signed [CMP_W-1:0] VEL_MIN = $signed(-VEL_LIM);
  localparam logic signed [REV_W-1:0] REV_POS = REV_W'(COUNTS_PER_REV);
  localparam logic signed [REV_W-1:0] REV_NEG = -REV_POS;

  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_TRACK} state_e;

  state_e                     state_q, state_d;
  logic [POS_WIDTH-1:0]       position_q, position_d;
  logic signed [VEL_WIDTH-1:0] velocity_q, velocity_d;
  logic                       velocity_valid_q, velocity_valid_d;
  logic                       homed_q, homed_d;
  logic                       homing_busy_q, homing_busy_d;
  logic                       index_error_q, index_error_d;
  logic                       index_prev_q, index_prev_d;
  logic signed [REV_W-1:0]    rev_count_q, rev_count_d;
  logic [CNT_W-1:0]           sample_cnt_q, sample_cnt_d;
  logic signed [ACC_W-1:0]    vel_acc_q, vel_acc_d;

  logic                       cnt_c;
  logic                       idx_edge_c;
  logic                       sample_tc_c;
  logic [POS_WIDTH-1:0]       pos_step_c;
  logic signed [REV_W-1:0]    rev_step_c;
  logic signed [ACC_W-1:0]    acc_sum_c;
  logic signed [CMP_W-1:0]    acc_ext_c;

  // Next-state, bookkeeping and velocity window logic.
  always_comb begin
    state_d          = state_q;
    position_d       = position_q;
    velocity_d       = velocity_q;
    velocity_valid_d = 1'b0;
    homed_d          = homed_q;
    index_error_d    = index_error_q;
    index_prev_d     = index;
    rev_count_d      = rev_count_q;
    sample_cnt_d     = sample_cnt_q;
    vel_acc_d        = vel_acc_q;

    cnt_c       = count_pulse & enable;
    idx_edge_c  = index & ~index_prev_q;
    sample_tc_c = (sample_cnt_q == CNT_W'(SAMPLE_DIV - 1));
    pos_step_c  = direction ? POS_WIDTH'(1) : {POS_WIDTH{1'b1}};
    rev_step_c  = cnt_c ? (direction ? REV_W'(1) : {REV_W{1'b1}}) : '0;
    acc_sum_c   = vel_acc_q + (cnt_c ? (direction ? ACC_W'(1) : {ACC_W{1'b1}}) : ACC_W'(0));
    acc_ext_c   = CMP_W'(acc_sum_c);

    if (cnt_c) begin
      position_d = position_q + pos_step_c;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_home) begin
          state_d       = ST_SEARCH;
          index_error_d = 1'b0;
        end
      end
      ST_SEARCH: begin
        if (idx_edge_c) begin
          state_d     = ST_TRACK;
          position_d  = '0;
          homed_d     = 1'b1;
          rev_count_d = '0;
        end
      end
      ST_TRACK: begin
        // Spacing is judged on the count before any same-cycle step.
        if (idx_edge_c) begin
          if ((rev_count_q != REV_POS) && (rev_count_q != REV_NEG)) begin
            index_error_d = 1'b1;
          end
          rev_count_d = rev_step_c;
        end else begin
          rev_count_d = rev_count_q + rev_step_c;
        end
        if (cmd_home) begin
          state_d       = ST_SEARCH;
          homed_d       = 1'b0;
          index_error_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cmd_clear) begin
      position_d = '0;
    end

    if (sample_tc_c) begin
      sample_cnt_d     = '0;
      vel_acc_d        = '0;
      velocity_valid_d = 1'b1;
      if (acc_ext_c > VEL_MAX) begin
        velocity_d = {1'b0, {(VEL_WIDTH - 1){1'b1}}};
      end else if (acc_ext_c < VEL_MIN) begin
        velocity_d = {1'b1, {(VEL_WIDTH - 1){1'b0}}};
      end else begin
        velocity_d = VEL_WIDTH'(acc_ext_c);
      end
    end else begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      vel_acc_d    = acc_sum_c;
    end

    homing_busy_d = (state_d == ST_SEARCH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      position_q       <= '0;
      velocity_q       <= '0;
      velocity_valid_q <= 1'b0;
      homed_q          <= 1'b0;
      homing_busy_q    <= 1'b0;
      index_error_q    <= 1'b0;
      index_prev_q     <= 1'b0;
      rev_count_q      <= '0;
      sample_cnt_q     <= '0;
      vel_acc_q        <= '0;
    end else begin
      state_q          <= state_d;
      position_q       <= position_d;
      velocity_q       <= velocity_d;
      velocity_valid_q <= velocity_valid_d;
      homed_q          <= homed_d;
      homing_busy_q    <= homing_busy_d;
      index_error_q    <= index_error_d;
      index_prev_q     <= index_prev_d;
      rev_count_q      <= rev_count_d;
      sample_cnt_q     <= sample_cnt_d;
      vel_acc_q        <= vel_acc_d;
    end
  end

  assign position       = position_q;
  assign velocity       = velocity_q;
  assign velocity_valid = velocity_valid_q;
  assign homed          = homed_q;
  assign homing_busy    = homing_busy_q;
  assign index_error    = index_error_q;

endmodule
